// File: rtl/aq_djpeg_defs.sv
// Shared definitions for the JPEG decoder YCbCr read path: FSM encoding and pixel widths.
package aq_djpeg_defs;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_NEXT  = 2'd2
  } state_t;

  localparam logic [7:0] MCU_LAST_ADDR = 8'd255;
  localparam int         PIX_W         = 9;
  localparam int         PIX_DATA_W    = 3 * PIX_W;

endpackage

// File: rtl/aq_djpeg_pix_stage.sv
// Single-entry valid/ready register stage carrying one YCbCr pixel and its buffer address.
module aq_djpeg_pix_stage
  import aq_djpeg_defs::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic [PIX_DATA_W-1:0] loadData,
  input  logic [7:0]            loadAddress,
  output logic                  inReady,
  output logic                  valid,
  input  logic                  ready,
  output logic [PIX_DATA_W-1:0] data,
  output logic [7:0]            address
);

  // A load in the same cycle as an accept replaces the entry, so the stream has no bubble.
  assign inReady = !valid || ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid   <= 1'b0;
      data    <= '0;
      address <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      data    <= loadData;
      address <= loadAddress;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/aq_djpeg_ycbcr_rdctl.sv
// Read-side sequencer for the YCbCr MCU buffer: scans one 16x16 bank, absorbs the
// buffer's registered read latency and streams pixels out with full backpressure.
module aq_djpeg_ycbcr_rdctl
  import aq_djpeg_defs::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             DataInit,
  input  logic             DataOutEnable,
  output logic [7:0]       DataOutAddress,
  output logic             DataOutRead,
  output logic             DataOutReadNext,
  input  logic [PIX_W-1:0] DataOutY,
  input  logic [PIX_W-1:0] DataOutCb,
  input  logic [PIX_W-1:0] DataOutCr,
  output logic             PixelValid,
  input  logic             PixelReady,
  output logic [PIX_W-1:0] PixelY,
  output logic [PIX_W-1:0] PixelCb,
  output logic [PIX_W-1:0] PixelCr,
  output logic [7:0]       PixelAddress,
  output logic             PixelFirst,
  output logic             PixelLast
);

  state_t                state;
  state_t                stateNext;
  logic   [7:0]          addrCnt;
  logic                  p1Valid;
  logic   [7:0]          p1Address;
  logic                  stageInReady;
  logic                  advance;
  logic   [PIX_DATA_W-1:0] pixData;

  // p1 holds no data of its own: the buffer output registers are the p1 data.
  assign advance        = p1Valid && stageInReady;
  assign DataOutAddress = addrCnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext       = state;
    DataOutRead     = 1'b0;
    DataOutReadNext = 1'b0;
    case (state)
      S_IDLE: begin
        if (DataOutEnable) begin
          stateNext = S_FETCH;
        end
      end
      S_FETCH: begin
        DataOutRead = !p1Valid || advance;
        if (DataOutRead && (addrCnt == MCU_LAST_ADDR)) begin
          stateNext = S_NEXT;
        end
      end
      S_NEXT: begin
        DataOutReadNext = !DataInit;
        stateNext       = S_IDLE;
      end
      default: begin
        stateNext = S_IDLE;
      end
    endcase
    if (DataInit) begin
      stateNext = S_IDLE;
    end
  end

  // The increment after address 255 lands on 0, which S_IDLE clears again anyway.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addrCnt <= '0;
    end else if (DataInit) begin
      addrCnt <= '0;
    end else if ((state == S_IDLE) && DataOutEnable) begin
      addrCnt <= '0;
    end else if (DataOutRead) begin
      addrCnt <= addrCnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1Valid   <= 1'b0;
      p1Address <= '0;
    end else if (DataInit) begin
      p1Valid <= 1'b0;
    end else if (DataOutRead) begin
      p1Valid   <= 1'b1;
      p1Address <= addrCnt;
    end else if (advance) begin
      p1Valid <= 1'b0;
    end
  end

  aq_djpeg_pix_stage uPixStage (
    .clk         (clk),
    .rst         (rst),
    .clear       (DataInit),
    .load        (advance),
    .loadData    ({DataOutY, DataOutCb, DataOutCr}),
    .loadAddress (p1Address),
    .inReady     (stageInReady),
    .valid       (PixelValid),
    .ready       (PixelReady),
    .data        (pixData),
    .address     (PixelAddress)
  );

  assign PixelY     = pixData[3*PIX_W-1:2*PIX_W];
  assign PixelCb    = pixData[2*PIX_W-1:PIX_W];
  assign PixelCr    = pixData[PIX_W-1:0];
  assign PixelFirst = (PixelAddress == 8'd0);
  assign PixelLast  = (PixelAddress == MCU_LAST_ADDR);

endmodule

// File: tb/tb_aq_djpeg_ycbcr_rdctl.sv
// Directed bench for the YCbCr read sequencer: behavioural MCU buffer plus a pixel scoreboard.
`timescale 1ns/1ps
module tb_aq_djpeg_ycbcr_rdctl;
  import aq_djpeg_defs::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       DataInit = 1'b0;
  logic       DataOutEnable = 1'b0;
  logic [7:0] DataOutAddress;
  logic       DataOutRead;
  logic       DataOutReadNext;
  logic [8:0] DataOutY = '0;
  logic [8:0] DataOutCb = '0;
  logic [8:0] DataOutCr = '0;
  logic       PixelValid;
  logic       PixelReady = 1'b0;
  logic [8:0] PixelY;
  logic [8:0] PixelCb;
  logic [8:0] PixelCr;
  logic [7:0] PixelAddress;
  logic       PixelFirst;
  logic       PixelLast;

  always #5 clk = ~clk;

  aq_djpeg_ycbcr_rdctl dut (
    .clk             (clk),
    .rst             (rst),
    .DataInit        (DataInit),
    .DataOutEnable   (DataOutEnable),
    .DataOutAddress  (DataOutAddress),
    .DataOutRead     (DataOutRead),
    .DataOutReadNext (DataOutReadNext),
    .DataOutY        (DataOutY),
    .DataOutCb       (DataOutCb),
    .DataOutCr       (DataOutCr),
    .PixelValid      (PixelValid),
    .PixelReady      (PixelReady),
    .PixelY          (PixelY),
    .PixelCb         (PixelCb),
    .PixelCr         (PixelCr),
    .PixelAddress    (PixelAddress),
    .PixelFirst      (PixelFirst),
    .PixelLast       (PixelLast)
  );

  int testsRun = 0;
  int failCount = 0;
  int cycle = 0;
  int banksLoaded = 0;
  int banksRead = 0;
  int readyMode = 1;  // 0 low, 1 high, 2 random, 3 stall on address 255
  int nextCount = 0;
  int firstNextCycle = -1;
  int read255Cycle = -100;
  int read0Cycle = -1;
  int acc0Cycle = 0;
  int acc255Cycle = 0;
  logic [36:0] expQ[$];

  function automatic logic [36:0] pixObs();
    return {PixelY, PixelCb, PixelCr, PixelAddress, PixelFirst, PixelLast};
  endfunction

  function automatic logic [36:0] pixExp(input int a);
    logic [7:0] ad;
    ad = 8'(a);
    return {9'(a), 9'(a + 1), 9'(a + 2), ad, ad == 8'd0, ad == 8'd255};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Making a bank available also queues the 256 pixels it must produce, in address order.
  task automatic applyStimulus(input int nBanks);
    for (int b = 0; b < nBanks; b++) begin
      for (int a = 0; a < 256; a++) expQ.push_back(pixExp(a));
      banksLoaded++;
    end
  endtask

  task automatic waitDrain(input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      @(posedge clk); #1;
      if (expQ.size() == 0 && banksRead == banksLoaded && !PixelValid) break;
    end
    repeat (4) @(posedge clk);
    #1;
    checkOutput("drained", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    logic       rdNow, nextNow, initNow, prevStall, prevInit, prevRead, anyRead, found;
    logic [7:0] rdAddr;
    logic [36:0] prevObs;
    logic [36:0] expPix;
    int reads;
    rdNow = 0; nextNow = 0; initNow = 0; prevStall = 0; prevInit = 0; prevRead = 0;
    rdAddr = '0; prevObs = '0;

    fork
      forever begin
        @(negedge clk);
        rdNow = DataOutRead; rdAddr = DataOutAddress; nextNow = DataOutReadNext; initNow = DataInit;
        if (PixelValid && PixelReady) begin
          checkOutput("sbEmpty", 64'(expQ.size() == 0), 64'd0);
          if (expQ.size() > 0) begin
            expPix = expQ.pop_front();
            checkOutput("pixel", 64'(pixObs()), 64'(expPix));
          end
          if (PixelAddress == 8'd0) acc0Cycle = cycle;
          if (PixelAddress == 8'd255) acc255Cycle = cycle;
        end
        if (prevStall && !prevInit)
          checkOutput("stableWhileStalled", 64'({PixelValid, pixObs()}), 64'({1'b1, prevObs}));
        if (prevRead && PixelValid && !PixelReady)
          checkOutput("noReadWhileP1Stalled", 64'(DataOutRead), 64'd0);
        if (DataOutRead && DataOutAddress == 8'd255) read255Cycle = cycle;
        if (DataOutRead && DataOutAddress == 8'd0) read0Cycle = cycle;
        if (DataOutReadNext) begin
          nextCount++;
          if (firstNextCycle < 0) firstNextCycle = cycle;
          checkOutput("nextAfterRead255", 64'(cycle - read255Cycle), 64'd1);
        end
        prevStall = PixelValid && !PixelReady;
        prevObs   = pixObs();
        prevInit  = DataInit;
        prevRead  = DataOutRead;

        @(posedge clk);
        cycle++;
        #2;
        if (initNow) begin
          banksRead = banksLoaded;
        end else begin
          if (rdNow) begin
            DataOutY  = 9'(rdAddr);
            DataOutCb = 9'(rdAddr) + 9'd1;
            DataOutCr = 9'(rdAddr) + 9'd2;
          end
          if (nextNow) banksRead++;
        end
        DataOutEnable = (banksLoaded > banksRead);
        case (readyMode)
          0:       PixelReady = 1'b0;
          2:       PixelReady = 1'($urandom_range(0, 1));
          3:       PixelReady = !(PixelValid && PixelAddress == 8'd255);
          default: PixelReady = 1'b1;
        endcase
      end
    join_none

    // Reset values, then a long idle stretch with no bank available.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstAddr", 64'(DataOutAddress), 64'd0);
    checkOutput("rstRead", 64'(DataOutRead), 64'd0);
    checkOutput("rstReadNext", 64'(DataOutReadNext), 64'd0);
    checkOutput("rstPixValid", 64'(PixelValid), 64'd0);
    checkOutput("rstPixData", 64'({PixelY, PixelCb, PixelCr, PixelAddress}), 64'd0);
    checkOutput("rstFirst", 64'(PixelFirst), 64'd1);
    checkOutput("rstLast", 64'(PixelLast), 64'd0);
    rst = 1'b1;
    anyRead = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      anyRead = anyRead | DataOutRead | PixelValid | DataOutReadNext;
    end
    checkOutput("idleQuiet", 64'(anyRead), 64'd0);

    // One bank, never stalled: 256 consecutive pixels and one bank release.
    readyMode = 1; nextCount = 0;
    applyStimulus(1);
    waitDrain(2000);
    checkOutput("t1NextCount", 64'(nextCount), 64'd1);
    checkOutput("t1Span", 64'(acc255Cycle - acc0Cycle), 64'd255);

    // Random backpressure.
    readyMode = 2; nextCount = 0;
    applyStimulus(1);
    waitDrain(5000);
    checkOutput("t2NextCount", 64'(nextCount), 64'd1);

    // Two banks back to back.
    readyMode = 1; nextCount = 0; firstNextCycle = -1;
    applyStimulus(2);
    waitDrain(3000);
    checkOutput("t3NextCount", 64'(nextCount), 64'd2);
    checkOutput("t3SecondFirstRead", 64'(read0Cycle - firstNextCycle), 64'd2);

    // Pixel 255 held at the output while the next bank is waiting.
    readyMode = 3; nextCount = 0;
    applyStimulus(2);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk); #1;
      found = PixelValid && PixelAddress == 8'd255;
    end
    checkOutput("t4Reach255", 64'(found), 64'd1);
    reads = 0;
    repeat (20) begin
      @(posedge clk); #1;
      reads += int'(DataOutRead);
    end
    checkOutput("t4ReadsDuringHold", 64'(reads), 64'd1);
    checkOutput("t4NextDuringHold", 64'(nextCount), 64'd1);
    checkOutput("t4Still255", 64'({PixelValid, PixelAddress}), 64'({1'b1, 8'd255}));
    readyMode = 1;
    waitDrain(3000);
    checkOutput("t4NextCount", 64'(nextCount), 64'd2);

    // Abort mid-fetch, then a clean restart from address 0.
    nextCount = 0;
    applyStimulus(1);
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(posedge clk); #1;
      found = DataOutRead && DataOutAddress == 8'd100;
    end
    checkOutput("t5Reach100", 64'(found), 64'd1);
    DataInit = 1'b1;
    @(posedge clk); #1;
    DataInit = 1'b0;
    checkOutput("t5PixValid", 64'(PixelValid), 64'd0);
    checkOutput("t5Read", 64'(DataOutRead), 64'd0);
    checkOutput("t5State", 64'(dut.state), 64'(S_IDLE));
    repeat (6) @(posedge clk);
    #1;
    checkOutput("t5NoNext", 64'(nextCount), 64'd0);
    expQ.delete();
    applyStimulus(1);
    waitDrain(2000);
    checkOutput("t5NextCount", 64'(nextCount), 64'd1);
    checkOutput("t5Span", 64'(acc255Cycle - acc0Cycle), 64'd255);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
